// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM fade/ramp duty source.
// Included by pwm_period_timer and pwm_fade_ramp.
package pwm_pkg;

    localparam int unsigned W_DEF  = 16;
    localparam int unsigned CW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } ramp_state_e;

endpackage

// File: rtl/pwm_period_timer.sv
// PWM period counter; period_wrap is registered and high on the last
// clock of each period, so it lines up with a PWM using the same counter.
module pwm_period_timer
    import pwm_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [W-1:0] period,
    output logic         period_wrap
);

    logic [W-1:0] r_cnt;
    logic         r_wrap;
    logic [W-1:0] w_last;
    logic [W-1:0] w_cnt_nxt;

    // period 0 and 1 both collapse to a one-clock period
    assign w_last    = (period == '0) ? '0 : period - W'(1);
    assign w_cnt_nxt = (r_cnt >= w_last) ? '0 : r_cnt + W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (!enable) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_wrap <= (w_cnt_nxt >= w_last);
        end
    end

    assign period_wrap = r_wrap;

endmodule

// File: rtl/pwm_fade_ramp.sv
// Breathing triangular duty source, updated only at PWM period boundaries.
// Optional cycle_done pulse enabled by PWM_FADE_DONE_IRQ_EN.
module pwm_fade_ramp
    import pwm_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [W-1:0]  period,
    input  logic [W-1:0]  duty_min,
    input  logic [W-1:0]  duty_max,
    input  logic [W-1:0]  step,
    input  logic [CW-1:0] periods_per_step,
    input  logic [CW-1:0] hold_periods,
    output logic [W-1:0]  duty_cycle,
    output logic          period_wrap,
    output logic [2:0]    ramp_state
`ifdef PWM_FADE_DONE_IRQ_EN
    ,
    output logic          cycle_done
`endif
);

    ramp_state_e   r_state;
    ramp_state_e   w_state_nxt;
    logic [W-1:0]  r_duty;
    logic [W-1:0]  w_duty_nxt;
    logic [CW-1:0] r_step_cnt;
    logic [CW-1:0] r_hold_cnt;
    logic [CW-1:0] w_pps;
    logic [CW-1:0] w_hold;
    logic          w_wrap;
    logic          w_step_evt;
    logic          w_hold_evt;
    logic          w_trans;
    logic [W:0]    w_sum;
    logic [W:0]    w_lo;

    pwm_period_timer #(
        .W(W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .period     (period),
        .period_wrap(w_wrap)
    );

    assign w_pps  = (periods_per_step == '0) ? CW'(1) : periods_per_step;
    assign w_hold = (hold_periods == '0) ? CW'(1) : hold_periods;

    // >= keeps events firing if the period count is lowered mid-count
    assign w_step_evt = w_wrap && (r_step_cnt >= w_pps - CW'(1));
    assign w_hold_evt = w_wrap && (r_hold_cnt >= w_hold - CW'(1));

    assign w_sum = {1'b0, r_duty} + {1'b0, step};
    assign w_lo  = {1'b0, duty_min} + {1'b0, step};

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        if (!enable) begin
            w_state_nxt = IDLE;
            w_duty_nxt  = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt = RAMP_UP;
                    w_duty_nxt  = duty_min;
                end
                RAMP_UP: begin
                    if (w_step_evt) begin
                        w_duty_nxt = (w_sum >= {1'b0, duty_max}) ?
                                     duty_max : w_sum[W-1:0];
                        if (w_duty_nxt == duty_max)
                            w_state_nxt = HOLD_HIGH;
                    end
                end
                HOLD_HIGH: begin
                    if (w_hold_evt)
                        w_state_nxt = RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    if (w_step_evt) begin
                        w_duty_nxt = ({1'b0, r_duty} < w_lo) ?
                                     duty_min : r_duty - step;
                        if (w_duty_nxt == duty_min)
                            w_state_nxt = HOLD_LOW;
                    end
                end
                HOLD_LOW: begin
                    if (w_hold_evt)
                        w_state_nxt = RAMP_UP;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_duty_nxt  = '0;
                end
            endcase
        end
    end

    assign w_trans = (w_state_nxt != r_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_duty  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cnt <= '0;
            r_hold_cnt <= '0;
        end else if (w_trans || r_state == IDLE) begin
            r_step_cnt <= '0;
            r_hold_cnt <= '0;
        end else if (w_wrap) begin
            r_step_cnt <= w_step_evt ? '0 : r_step_cnt + CW'(1);
            r_hold_cnt <= w_hold_evt ? '0 : r_hold_cnt + CW'(1);
        end
    end

`ifdef PWM_FADE_DONE_IRQ_EN
    logic r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_done <= 1'b0;
        else
            r_done <= (r_state == HOLD_LOW) && (w_state_nxt == RAMP_UP);
    end

    assign cycle_done = r_done;
`endif

    assign duty_cycle  = r_duty;
    assign period_wrap = w_wrap;
    assign ramp_state  = r_state;

endmodule

// File: tb/tb_pwm_fade_ramp.sv
// Directed bench for pwm_fade_ramp with hand-computed duty sequences.
// Checks cycle_done too when PWM_FADE_DONE_IRQ_EN is defined.
module tb_pwm_fade_ramp;

    localparam int W  = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [W-1:0]  period;
    logic [W-1:0]  duty_min;
    logic [W-1:0]  duty_max;
    logic [W-1:0]  step;
    logic [CW-1:0] pps;
    logic [CW-1:0] hold;
    logic [W-1:0]  duty_cycle;
    logic          period_wrap;
    logic [2:0]    ramp_state;
`ifdef PWM_FADE_DONE_IRQ_EN
    logic          cycle_done;
`endif

    int checks = 0;
    int errors = 0;
    int g;

    int e1_d[9]  = '{5, 10, 10, 10, 5, 0, 0, 0, 5};
    int e1_s[9]  = '{1, 2, 2, 3, 3, 4, 4, 1, 1};
    int e2_d[11] = '{3, 6, 9, 10, 10, 7, 4, 1, 0, 0, 3};
    int e2_s[11] = '{1, 1, 1, 2, 3, 3, 3, 3, 4, 1, 1};
    int e3_d[6]  = '{0, 0, 5, 5, 5, 10};
    int e5_d[7]  = '{5, 10, 10, 5, 0, 0, 5};
    int e6_d[5]  = '{4, 4, 8, 8, 4};
    int e6_s[5]  = '{2, 3, 4, 1, 2};

    pwm_fade_ramp #(
        .W (W),
        .CW(CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .period          (period),
        .duty_min        (duty_min),
        .duty_max        (duty_max),
        .step            (step),
        .periods_per_step(pps),
        .hold_periods    (hold),
        .duty_cycle      (duty_cycle),
        .period_wrap     (period_wrap),
        .ramp_state      (ramp_state)
`ifdef PWM_FADE_DONE_IRQ_EN
        ,
        .cycle_done      (cycle_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic setup(input int p, input int mn, input int mx,
                         input int st, input int ps, input int hd);
        period   = W'(p);
        duty_min = W'(mn);
        duty_max = W'(mx);
        step     = W'(st);
        pps      = CW'(ps);
        hold     = CW'(hd);
    endtask

    task automatic start();
        enable = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic stop();
        enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // returns #1 after the edge that consumed the next period_wrap
    task automatic next_wrap(output int gap);
        gap = 0;
        while (gap < 200) begin
            @(negedge clk);
            gap++;
            if (period_wrap) break;
        end
        if (!period_wrap) chk("wrap_timeout", 32'(period_wrap), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        setup(10, 0, 10, 5, 1, 2);
        #12;
        chk("rst_duty", 32'(duty_cycle), 0);
        chk("rst_wrap", 32'(period_wrap), 0);
        chk("rst_state", 32'(ramp_state), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic triangle, hold of two periods
        start();
        chk("t1_load_state", 32'(ramp_state), 1);
        chk("t1_load_duty", 32'(duty_cycle), 0);
        for (int i = 0; i < 9; i++) begin
            next_wrap(g);
            chk($sformatf("t1_duty%0d", i), 32'(duty_cycle), 32'(e1_d[i]));
            chk($sformatf("t1_st%0d", i), 32'(ramp_state), 32'(e1_s[i]));
            if (i > 0) chk($sformatf("t1_gap%0d", i), 32'(g), 10);
        end

        // disable mid-ramp at duty 5, then restart from a new minimum
        stop();
        chk("dis_state", 32'(ramp_state), 0);
        chk("dis_duty", 32'(duty_cycle), 0);
        duty_min = W'(2);
        start();
        chk("reen_state", 32'(ramp_state), 1);
        chk("reen_duty", 32'(duty_cycle), 2);
        stop();

        // step 3 clamps at both ends
        setup(10, 0, 10, 3, 1, 1);
        start();
        for (int i = 0; i < 11; i++) begin
            next_wrap(g);
            chk($sformatf("t2_duty%0d", i), 32'(duty_cycle), 32'(e2_d[i]));
            chk($sformatf("t2_st%0d", i), 32'(ramp_state), 32'(e2_s[i]));
        end
        stop();

        // three periods per step, then zero behaving as one
        setup(10, 0, 10, 5, 3, 1);
        start();
        for (int i = 0; i < 6; i++) begin
            next_wrap(g);
            chk($sformatf("t3_duty%0d", i), 32'(duty_cycle), 32'(e3_d[i]));
        end
        stop();
        pps = '0;
        start();
        next_wrap(g);
        chk("t3_pps0_a", 32'(duty_cycle), 5);
        next_wrap(g);
        chk("t3_pps0_b", 32'(duty_cycle), 10);
        stop();

        // async reset in HOLD_HIGH, no clock edge needed
        setup(10, 0, 10, 5, 1, 8);
        start();
        next_wrap(g);
        next_wrap(g);
        chk("t4_hh_state", 32'(ramp_state), 2);
        chk("t4_hh_duty", 32'(duty_cycle), 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_ar_duty", 32'(duty_cycle), 0);
        chk("t4_ar_state", 32'(ramp_state), 0);
        chk("t4_ar_wrap", 32'(period_wrap), 0);
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);

        // period 1: wrap and step every clock
        setup(1, 0, 10, 5, 1, 1);
        start();
        chk("t5_wrap_now", 32'(period_wrap), 1);
        for (int i = 0; i < 7; i++) begin
            next_wrap(g);
            chk($sformatf("t5_duty%0d", i), 32'(duty_cycle), 32'(e5_d[i]));
            chk($sformatf("t5_gap%0d", i), 32'(g), 1);
`ifdef PWM_FADE_DONE_IRQ_EN
            chk($sformatf("t5_done%0d", i), 32'(cycle_done),
                (i == 5) ? 32'd1 : 32'd0);
`endif
        end
        stop();

        // duty_min above duty_max gives a square toggle
        setup(1, 8, 4, 1, 1, 1);
        start();
        chk("t6_load", 32'(duty_cycle), 8);
        for (int i = 0; i < 5; i++) begin
            next_wrap(g);
            chk($sformatf("t6_duty%0d", i), 32'(duty_cycle), 32'(e6_d[i]));
            chk($sformatf("t6_st%0d", i), 32'(ramp_state), 32'(e6_s[i]));
        end
        stop();

        // step 0 sits at duty_min in RAMP_UP
        setup(1, 0, 10, 0, 1, 1);
        start();
        for (int i = 0; i < 3; i++) begin
            next_wrap(g);
            chk($sformatf("t7_duty%0d", i), 32'(duty_cycle), 0);
            chk($sformatf("t7_st%0d", i), 32'(ramp_state), 1);
        end
        stop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_fade_ramp.md
Name: pwm_fade_ramp

Overview:
- Upstream duty-cycle source for the PWM generator: produces a "breathing" triangular duty profile on `duty_cycle`.
- Ramps between programmable min/max bounds, with programmable step size, step rate and hold times.
- Updates occur only at PWM period boundaries, so the downstream PWM never sees a mid-period duty change.
- Shares `period` with the PWM and mirrors its counter (wrap at `period-1`).

Parameters:
- W, 16, width of duty/period/step datapath
- CW, 8, width of step-rate and hold counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  run ramp; low forces IDLE
- period  in  W  PWM period in clocks; same value fed to the PWM
- duty_min  in  W  lower duty bound
- duty_max  in  W  upper duty bound
- step  in  W  duty increment/decrement per step event
- periods_per_step  in  CW  PWM periods per step event; 0 treated as 1
- hold_periods  in  CW  PWM periods held at each extreme; 0 treated as 1
- duty_cycle  out  W  registered duty to the PWM
- period_wrap  out  1  one-clock pulse on the last clock of each PWM period
- ramp_state  out  3  current FSM state encoding

Behaviour:
- Reset (async, `rst_n`=0):
  - `duty_cycle`=0, `period_wrap`=0, `ramp_state`=IDLE.
  - All counters cleared.
- Period counter:
  - Runs only while `enable`=1.
  - Wraps to 0 when `cnt >= period-1`, otherwise increments.
  - `period_wrap`=1 on the wrap clock; registered, aligned with the PWM counter when both are released together.
  - `period` 0 or 1 → `period_wrap` every clock.
- Step event:
  - Step counter counts `period_wrap` pulses; step event fires on the wrap that completes `max(periods_per_step,1)` periods, then the counter clears.
  - Hold counter is identical, using `max(hold_periods,1)`.
- FSM states: IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW.
  - IDLE: `duty_cycle`=0. On `enable`=1 → RAMP_UP next clock, `duty_cycle` loaded with `duty_min` on that same clock.
  - RAMP_UP: at each step event, `duty_cycle` = min(`duty_cycle`+`step`, `duty_max`). The sum is computed at W+1 bits, so there is no wrap-around. On reaching `duty_max` → HOLD_HIGH.
  - HOLD_HIGH: at hold expiry → RAMP_DOWN.
  - RAMP_DOWN: at each step event, `duty_cycle` = `duty_min` if `duty_cycle` < `duty_min`+`step`, else `duty_cycle`−`step`; no underflow. On reaching `duty_min` → HOLD_LOW.
  - HOLD_LOW: at hold expiry → RAMP_UP.
- `duty_cycle` changes only on a `period_wrap` clock, except the IDLE→RAMP_UP load.
- Step/hold counters clear on every state transition.
- Degenerate settings:
  - `step`=0: duty stays at `duty_min` in RAMP_UP indefinitely.
  - `duty_min` >= `duty_max`: RAMP_UP clamps to `duty_max` at the first step event; RAMP_DOWN clamps to `duty_min`. The profile becomes a square toggle between the two values, which is legal.
- `enable` deasserted (any state, including mid-ramp): next clock → IDLE, `duty_cycle`=0, counters cleared. Re-enable restarts from `duty_min`.
- Bound/step changes mid-ramp take effect at the next step event. The clamp uses the current `duty_max`/`duty_min`. If `duty_cycle` is already beyond the new bound, it clamps at the next step event and the FSM transitions.
- Async reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro: `PWM_FADE_DONE_IRQ_EN`.
- With the macro: extra output `cycle_done` (1 bit), a one-clock pulse on the HOLD_LOW→RAMP_UP transition. Reset value 0; forced 0 in IDLE.
- Without the macro: port absent; no logic.

Decomposition:
- Shared package `pwm_pkg`:
  - FSM state typedef: IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.
  - Default widths W=16, CW=8.
- Sub-module `pwm_period_timer`: period counter plus `period_wrap` generation. Reused by the PWM for counter alignment.

Test Plan:
- Setup: `period`=10, `duty_min`=0, `duty_max`=10, `step`=5, `periods_per_step`=1, `hold_periods`=2; enable.
  - Required `duty_cycle` per wrap: 0 initially, then 5, 10, 10, 10 (HOLD_HIGH), 5, 0, 0, 0 (HOLD_LOW), then 5.
  - `period_wrap` every 10 clocks.
- `step`=3, `duty_max`=10 → up sequence 0, 3, 6, 9, 10 (clamped); down sequence 7, 4, 1, 0 (clamped); no wrap-around.
- `periods_per_step`=3 → duty changes only on every 3rd `period_wrap`. With `periods_per_step`=0 → behaves as 1.
- Deassert `enable` while `duty_cycle`=5 in RAMP_UP → next clock IDLE, `duty_cycle`=0. Re-enable → restarts at `duty_min`.
- Assert `rst_n`=0 asynchronously mid-HOLD_HIGH → outputs 0 and `ramp_state`=IDLE without a clock edge.
- `period`=1 → `period_wrap` high every clock, a step event every clock. With `PWM_FADE_DONE_IRQ_EN`: `cycle_done` pulses exactly once per full triangle.
